// File: rtl/trace_capture_ctrl_if.sv
// rtl/trace_capture_ctrl_if.sv - waveform memory write port for the trace capture sequencer
interface trace_capture_ctrl_if #(
    parameter int ADDR_W = 13
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic              wr_en;
    logic [7:0]        wave_data;

    modport master (output mem_addr, output wr_en, output wave_data);
    modport slave  (input  mem_addr, input  wr_en, input  wave_data);
endinterface

// File: rtl/trace_capture_ctrl.sv
// rtl/trace_capture_ctrl.sv - arm/trigger/delay/capture sequencer writing ADC samples to waveform memory
module trace_capture_ctrl #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 1024,
    parameter int DLY_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 trig,
    input  logic [DLY_W-1:0]     delay,
    input  logic [ADDR_W-1:0]    nsamp,
    input  logic [7:0]           adc_data,
    trace_capture_ctrl_if.master mem,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        CAPTURE,
        FINISHED
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_V = ADDR_W'(DEPTH);

    state_t            state;
    logic [DLY_W-1:0]  dcnt;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] trig_last_addr;

    // Zero or oversized requests capture the whole memory.
    always_comb begin
        trig_last_addr = DEPTH_V - ADDR_W'(1);
        if (nsamp != '0 && nsamp <= DEPTH_V) begin
            trig_last_addr = nsamp - ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            dcnt          <= '0;
            last_addr     <= '0;
            mem.mem_addr  <= '0;
            mem.wr_en     <= 1'b0;
            mem.wave_data <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ovf           <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            mem.wr_en <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        state <= ARMED;
                        busy  <= 1'b1;
                        ovf   <= 1'b0;
                    end
                end
                ARMED: begin
                    if (trig) begin
                        last_addr <= trig_last_addr;
                        if (delay == '0) begin
                            state         <= CAPTURE;
                            mem.wr_en     <= 1'b1;
                            mem.mem_addr  <= '0;
                            mem.wave_data <= adc_data;
                        end else begin
                            state <= DELAY;
                            dcnt  <= delay;
                        end
                    end
                end
                DELAY: begin
                    if (trig) begin
                        ovf <= 1'b1;
                    end
                    dcnt <= dcnt - DLY_W'(1);
                    if (dcnt == DLY_W'(1)) begin
                        state         <= CAPTURE;
                        mem.wr_en     <= 1'b1;
                        mem.mem_addr  <= '0;
                        mem.wave_data <= adc_data;
                    end
                end
                CAPTURE: begin
                    if (trig) begin
                        ovf <= 1'b1;
                    end
                    // mem_addr holds the final address afterwards; it never steps past it.
                    if (mem.mem_addr == last_addr) begin
                        state     <= FINISHED;
                        mem.wr_en <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        mem.mem_addr  <= mem.mem_addr + ADDR_W'(1);
                        mem.wave_data <= adc_data;
                    end
                end
                FINISHED: begin
                    if (arm) begin
                        state <= ARMED;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem.wr_en <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// tb/tb_trace_capture_ctrl.sv - randomized bench for trace_capture_ctrl against a capture-window model
module tb_trace_capture_ctrl;
    localparam int ADDR_W = 13;
    localparam int DEPTH  = 1024;
    localparam int DLY_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic              trig = 1'b0;
    logic [DLY_W-1:0]  delay = '0;
    logic [ADDR_W-1:0] nsamp = '0;
    logic [7:0]        adc_data = '0;
    logic              busy;
    logic              done;
    logic              ovf;

    trace_capture_ctrl_if #(.ADDR_W(ADDR_W)) mem_bus ();

    trace_capture_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DLY_W(DLY_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .abort    (abort),
        .trig     (trig),
        .delay    (delay),
        .nsamp    (nsamp),
        .adc_data (adc_data),
        .mem      (mem_bus.master),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: a capture is a window of cycle numbers [t_first, t_last] fixed at trig time.
    bit m_armed, m_active, m_done, m_ovf;
    int t_first, t_last, m_addr, cyc;
    int wr_cnt, first_wr, last_wr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_active = 0; m_done = 0; m_ovf = 0;
        t_first = 0; t_last = -1; m_addr = 0;
    endtask

    task automatic tick(input bit a, input bit ab, input bit t);
        logic [7:0] s_adc;
        int d, n;
        bit exp_wr;
        arm = a; abort = ab; trig = t;
        adc_data = 8'($urandom);
        s_adc = adc_data;
        d = int'(delay);
        n = (nsamp == 0 || int'(nsamp) > DEPTH) ? DEPTH : int'(nsamp);
        @(posedge clk);
        #1;
        if (ab) begin
            m_armed = 0; m_active = 0; m_done = 0;
        end else if (a && !m_armed && !m_active) begin
            m_armed = 1; m_done = 0; m_ovf = 0;
        end else if (t && m_armed) begin
            m_armed = 0; m_active = 1;
            t_first = cyc + 1 + d;
            t_last  = cyc + d + n;
        end else if (t && m_active) begin
            m_ovf = 1;
        end
        if (m_active && cyc + 1 > t_last) begin
            m_active = 0; m_done = 1;
        end
        cyc++;
        exp_wr = m_active && cyc >= t_first;
        if (exp_wr) m_addr = cyc - t_first;
        chk("busy", 32'(busy), 32'(m_armed || m_active));
        chk("done", 32'(done), 32'(m_done));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("wr_en", 32'(mem_bus.wr_en), 32'(exp_wr));
        chk("mem_addr", 32'(mem_bus.mem_addr), m_addr);
        if (exp_wr) chk("wave_data", 32'(mem_bus.wave_data), 32'(s_adc));
        if (mem_bus.wr_en) begin
            wr_cnt++;
            if (wr_cnt == 1) first_wr = cyc;
            last_wr = cyc;
        end
        arm = 1'b0; abort = 1'b0; trig = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, 32'(mem_bus.wr_en), 32'(0));
        chk({tag, "_mem_addr"}, 32'(mem_bus.mem_addr), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_ovf"}, 32'(ovf), 32'(0));
    endtask

    int tc;

    initial begin
        model_reset();
        cyc = 0; wr_cnt = 0; first_wr = -1; last_wr = -1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        chk("por_wave_data", 32'(mem_bus.wave_data), 32'(0));
        rst = 1'b0;

        // trig with no arm is ignored
        delay = 0; nsamp = 4;
        tick(0, 0, 1);
        idle(6);
        chk("noarm_writes", wr_cnt, 0);

        // delay 5, nsamp 8: writes in cycles trig+6 .. trig+13
        tick(1, 0, 0);
        idle(3);
        delay = 5; nsamp = 8; wr_cnt = 0; tc = cyc;
        tick(0, 0, 1);
        delay = 16'($urandom_range(1, 50)); nsamp = 13'($urandom_range(1, 50));
        idle(15);
        chk("d5_first", first_wr, tc + 6);
        chk("d5_last", last_wr, tc + 13);
        chk("d5_count", wr_cnt, 8);
        chk("d5_done", 32'(done), 32'(1));

        // nsamp 0 and nsamp 2000 both capture the full memory
        for (int k = 0; k < 2; k++) begin
            tick(1, 0, 0);
            delay = 0; nsamp = (k == 0) ? 13'd0 : 13'd2000; wr_cnt = 0; tc = cyc;
            tick(0, 0, 1);
            idle(DEPTH + 4);
            chk("full_first", first_wr, tc + 1);
            chk("full_count", wr_cnt, DEPTH);
            chk("full_last_addr", 32'(mem_bus.mem_addr), 32'(DEPTH - 1));
            chk("full_done", 32'(done), 32'(1));
        end

        // second trig during capture sets ovf but does not disturb the capture
        tick(1, 0, 0);
        delay = 2; nsamp = 10; wr_cnt = 0;
        tick(0, 0, 1);
        idle(5);
        tick(0, 0, 1);
        idle(12);
        chk("ovf_count", wr_cnt, 10);
        chk("ovf_set", 32'(ovf), 32'(1));
        tick(1, 0, 0);
        chk("ovf_cleared", 32'(ovf), 32'(0));

        // abort during DELAY
        delay = 10; nsamp = 5;
        tick(0, 0, 1);
        idle(3);
        wr_cnt = 0;
        tick(0, 1, 0);
        idle(20);
        chk("abort_delay_writes", wr_cnt, 0);

        // abort during CAPTURE
        tick(1, 0, 0);
        delay = 1; nsamp = 20;
        tick(0, 0, 1);
        idle(6);
        wr_cnt = 0;
        tick(0, 1, 0);
        idle(10);
        chk("abort_cap_writes", wr_cnt, 0);
        chk("abort_cap_busy", 32'(busy), 32'(0));

        // abort wins over arm
        tick(1, 1, 0);
        idle(2);
        chk("abort_arm_busy", 32'(busy), 32'(0));

        // from DONE: arm, then single write two cycles after trig
        tick(1, 0, 0);
        delay = 0; nsamp = 3;
        tick(0, 0, 1);
        idle(5);
        tick(1, 0, 0);
        delay = 1; nsamp = 1; wr_cnt = 0; tc = cyc;
        tick(0, 0, 1);
        idle(4);
        chk("single_count", wr_cnt, 1);
        chk("single_first", first_wr, tc + 2);
        chk("single_done", 32'(done), 32'(1));

        // asynchronous reset mid-capture
        tick(1, 0, 0);
        delay = 0; nsamp = 50;
        tick(0, 0, 1);
        idle(10);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        wr_cnt = 0;
        idle(10);
        chk("rst_mid_writes", wr_cnt, 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) delay = 16'($urandom_range(0, 20));
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 5))
                    0:       nsamp = 13'd0;
                    1:       nsamp = 13'($urandom_range(1000, 1100));
                    default: nsamp = 13'($urandom_range(1, 40));
                endcase
            end
            tick(($urandom_range(0, 19) == 0), ($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 14) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
